// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared arbiter definitions: state and grant encodings
// Purpose: state encoding and grant encoding shared by the arbiter and its bench.
// Ports: none (package).
package mem_port_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE   = 2'd0;
  localparam arb_state_t BUSY_D = 2'd1;
  localparam arb_state_t BUSY_I = 2'd2;

  // Grant encoding doubles as the mem_sel / address-mux select value.
  localparam logic GNT_D = 1'b0;
  localparam logic GNT_I = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// rtl/mem_port_arbiter_mux.sv - n-bit 2:1 multiplexer used on the arbiter address path
// Purpose: out = sel ? B : A.
// Ports: A (sel=0 input), B (sel=1 input), sel, out.
module N_Bit_2X1_MUX #(
  parameter int n = 32
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         sel,
  output logic [n-1:0] out
);

  assign out = sel ? B : A;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data round-robin arbiter for a single-ported memory
// Purpose: grants the shared memory to the fetch or load/store port, drives the
//   registered memory address/strobes, counts LAT cycles and pulses a one-cycle ack.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req, if_addr          fetch request / address
//   d_req, d_we, d_addr      load/store request / write enable / address
//   mem_en, mem_we, mem_addr memory access strobes and registered address
//   mem_sel                  1 = fetch port owns the memory, 0 = data port
//   if_ack, d_ack            one-cycle completion pulses
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic          mem_sel,
  output logic          if_ack,
  output logic          d_ack
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_grant_q;
  logic             mem_en_q, mem_we_q, mem_sel_q;
  logic [AW-1:0]    mem_addr_q;

  logic             grant_valid;
  logic             grant_sel;
  logic             cnt_zero;
  logic [AW-1:0]    addr_mux;

  assign cnt_zero = (cnt_q == '0);

  N_Bit_2X1_MUX #(.n(AW)) u_addr_mux (
    .A   (d_addr),
    .B   (if_addr),
    .sel (grant_sel),
    .out (addr_mux)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and grant decision. At a completion edge only the other port
  // may be granted, which keeps a streaming port from locking out its peer.
  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    grant_sel   = GNT_D;
    case (state_q)
      IDLE: begin
        if (if_req && d_req) begin
          grant_valid = 1'b1;
          grant_sel   = ~last_grant_q;
        end else if (d_req) begin
          grant_valid = 1'b1;
          grant_sel   = GNT_D;
        end else if (if_req) begin
          grant_valid = 1'b1;
          grant_sel   = GNT_I;
        end
      end
      BUSY_D: begin
        if (cnt_zero) begin
          if (if_req) begin
            grant_valid = 1'b1;
            grant_sel   = GNT_I;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BUSY_I: begin
        if (cnt_zero) begin
          if (d_req) begin
            grant_valid = 1'b1;
            grant_sel   = GNT_D;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_valid) state_d = (grant_sel == GNT_I) ? BUSY_I : BUSY_D;
  end

  // Outputs: acks are combinational so they land in the last counted cycle.
  always_comb begin
    if_ack = (state_q == BUSY_I) && cnt_zero;
    d_ack  = (state_q == BUSY_D) && cnt_zero;
  end

  // Datapath: counter, round-robin history and registered memory interface.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      last_grant_q <= GNT_I;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else if (grant_valid) begin
      cnt_q        <= CNT_W'(LAT - 1);
      last_grant_q <= grant_sel;
      mem_en_q     <= 1'b1;
      mem_we_q     <= (grant_sel == GNT_D) ? d_we : 1'b0;
      mem_sel_q    <= grant_sel;
      mem_addr_q   <= addr_mux;
    end else if (state_d == IDLE) begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_sel  = mem_sel_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at LAT 1, 2 and 3
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Requester controls, changed by the sequencer at posedge+2.
  int          p_if = 0;
  int          p_d  = 0;
  bit          rand_addr = 1'b0;
  logic [31:0] dir_if_addr = 32'h100;
  logic [31:0] dir_d_addr  = 32'h2000;
  logic        dir_d_we    = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      if (fails < 40) $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  typedef struct {
    bit          en, we, sel, ia, da;
    logic [31:0] addr;
  } exp_t;

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int L = g + 1;

    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr;
    logic        mem_en, mem_we, mem_sel, if_ack, d_ack;
    logic [31:0] mem_addr;

    mem_port_arbiter #(.AW(32), .LAT(L)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_sel  (mem_sel),
      .if_ack   (if_ack),
      .d_ack    (d_ack)
    );

    // Requesters: hold req until the ack cycle, then optionally issue the next.
    initial begin
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; if_addr = '0; d_addr = '0;
      forever begin
        @(posedge clk); #1;
        if (!if_req || if_ack) begin
          if (int'($urandom_range(99)) < p_if) begin
            if_req  = 1'b1;
            if_addr = rand_addr ? ($urandom() & 32'hFFFF_FFFC) : dir_if_addr;
          end else if_req = 1'b0;
        end
        if (!d_req || d_ack) begin
          if (int'($urandom_range(99)) < p_d) begin
            d_req  = 1'b1;
            d_addr = rand_addr ? ($urandom() & 32'hFFFF_FFFC) : dir_d_addr;
            d_we   = rand_addr ? 1'($urandom_range(1)) : dir_d_we;
          end else d_req = 1'b0;
        end
      end
    end

    // Reference model: transaction view (who owns the memory, at which cycle
    // its ack is due). Edge e closes cycle e; its prediction is for cycle e+1.
    exp_t q[$];
    initial begin
      int          busy;
      int          last;
      int          gp;
      longint      e;
      longint      ack_at;
      exp_t        x;
      busy = -1; last = 1; e = 0; ack_at = -1;
      x = '{en: 0, we: 0, sel: 0, ia: 0, da: 0, addr: '0};
      forever begin
        @(posedge clk);
        if (rst) begin
          busy = -1; last = 1;
          x = '{en: 0, we: 0, sel: 0, ia: 0, da: 0, addr: '0};
        end else begin
          gp = -1;
          if (busy >= 0 && e == ack_at) begin
            if ((busy == 0) ? if_req : d_req) gp = 1 - busy;
            else begin busy = -1; x.en = 0; x.we = 0; end
          end else if (busy < 0) begin
            if (if_req && d_req) gp = 1 - last;
            else if (d_req)      gp = 0;
            else if (if_req)     gp = 1;
          end
          if (gp >= 0) begin
            busy   = gp;
            last   = gp;
            ack_at = e + L;
            x.en   = 1;
            x.sel  = (gp == 1);
            x.addr = (gp == 1) ? if_addr : d_addr;
            x.we   = (gp == 1) ? 1'b0 : d_we;
          end
        end
        e++;
        x.ia = (busy == 1) && (ack_at == e);
        x.da = (busy == 0) && (ack_at == e);
        q.push_back(x);
      end
    end

    // Monitor: compares every cycle at the falling edge; also bounds waiting.
    initial begin
      exp_t  x;
      int    w_i, w_d;
      string nm;
      nm = $sformatf("L%0d", L);
      w_i = 0; w_d = 0;
      forever begin
        @(negedge clk);
        if (q.size() != 0) begin
          x = q.pop_front();
          chk({nm, " mem_en"},   32'(mem_en),  32'(x.en));
          chk({nm, " mem_we"},   32'(mem_we),  32'(x.we));
          chk({nm, " mem_sel"},  32'(mem_sel), 32'(x.sel));
          chk({nm, " mem_addr"}, mem_addr,     x.addr);
          chk({nm, " if_ack"},   32'(if_ack),  32'(x.ia));
          chk({nm, " d_ack"},    32'(d_ack),   32'(x.da));
          chk({nm, " both_ack"}, 32'(if_ack && d_ack), 32'(0));
        end
        if (rst) begin
          w_i = 0; w_d = 0;
        end else begin
          if (if_req && if_ack) begin
            chk({nm, " if_wait_bound"}, 32'(w_i <= 2 * L + 1), 32'(1));
            w_i = 1;
          end else if (if_req) w_i++;
          else w_i = 0;
          if (d_req && d_ack) begin
            chk({nm, " d_wait_bound"}, 32'(w_d <= 2 * L + 1), 32'(1));
            w_d = 1;
          end else if (d_req) w_d++;
          else w_d = 0;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    // Single fetch at 0x100.
    p_if = 100; cyc(1); p_if = 0; cyc(8);
    // Tie from reset: store 0x2000 vs fetch 0x104.
    rst = 1'b1; cyc(2); rst = 1'b0;
    dir_if_addr = 32'h104; dir_d_addr = 32'h2000; dir_d_we = 1'b1;
    p_if = 100; p_d = 100; cyc(1); p_if = 0; p_d = 0; cyc(12);
    // Continuous fetch stream.
    dir_if_addr = 32'h100;
    p_if = 100; cyc(12); p_if = 0; cyc(10);
    // Single load at 0x40.
    dir_d_addr = 32'h40; dir_d_we = 1'b0;
    p_d = 100; cyc(1); p_d = 0; cyc(8);
    // Reset during a store access; request stays up and is re-served.
    dir_d_we = 1'b1;
    p_d = 100; cyc(1); p_d = 0; cyc(2);
    rst = 1'b1; cyc(1); rst = 1'b0; cyc(12);
    // Random traffic with occasional resets.
    rand_addr = 1'b1;
    for (int i = 0; i < 9000; i++) begin
      if (i % 50 == 0) begin
        p_if = int'($urandom_range(100));
        p_d  = int'($urandom_range(100));
      end
      rst = ($urandom_range(499) == 0);
      cyc(1);
    end
    rst = 1'b0; p_if = 0; p_d = 0; cyc(60);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
